// File: rtl/flag_pkg.sv
// Shared definitions for the flag context block: update modes and default sizing.
package flag_pkg;

    typedef enum logic [1:0] {
        FLAG_LOAD   = 2'b00,
        FLAG_SET    = 2'b01,
        FLAG_CLEAR  = 2'b10,
        FLAG_TOGGLE = 2'b11
    } flag_mode_e;

    localparam int FLAG_WIDTH = 8;
    localparam int FLAG_DEPTH = 4;

endpackage

// File: rtl/flag_lifo.sv
// Context-save LIFO: storage, occupancy pointer and full/empty status.
// The caller guarantees push/pop/swap are mutually exclusive and legal.
module flag_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             swap,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (!rst_n)
            depth <= '0;
        else if (push)
            depth <= depth + DW'(1);
        else if (pop)
            depth <= depth - DW'(1);
    end

    // Push writes the slot at depth; swap overwrites the current top slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_n && ((push && depth == DW'(i)) || (swap && depth == DW'(i + 1))))
                mem[i] <= din;
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth == DW'(i + 1))
                top = mem[i];
        end
    end

    assign full  = (depth == DW'(DEPTH));
    assign empty = (depth == '0);

endmodule

// File: rtl/flag_ctx.sv
// Flag register with masked LOAD/SET/CLEAR/TOGGLE updates, a save/restore
// stack for interrupt entry/return, and sticky overflow/underflow errors.
module flag_ctx
    import flag_pkg::*;
#(
    parameter int WIDTH = FLAG_WIDTH,
    parameter int DEPTH = FLAG_DEPTH,
    localparam int DW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Flagin,
    input  logic             wrflag,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mask,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Flagout,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);

    logic [WIDTH-1:0] operand, updated, top, next_flags;
    logic             do_push, do_pop, do_swap, ovf_set, unf_set;

    // A rejected pop degrades push+pop to a plain push.
    assign do_swap = push & pop & ~empty;
    assign do_pop  = pop & ~push & ~empty;
    assign do_push = push & ~full & (~pop | empty);
    assign ovf_set = push & ~pop & full;
    assign unf_set = pop & empty;

    always_comb begin
        operand = Flagin & mask;
        updated = Flagout;
        case (flag_mode_e'(mode))
            FLAG_LOAD:   updated = (Flagout & ~mask) | operand;
            FLAG_SET:    updated = Flagout | operand;
            FLAG_CLEAR:  updated = Flagout & ~operand;
            FLAG_TOGGLE: updated = Flagout ^ operand;
            default:     updated = Flagout;
        endcase

        next_flags = Flagout;
        if (do_swap || do_pop)
            next_flags = top;
        else if (wrflag)
            next_flags = updated;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            Flagout <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            Flagout <= next_flags;
            ovf_err <= ovf_set | (ovf_err & ~clr_err);
            unf_err <= unf_set | (unf_err & ~clr_err);
        end
    end

    flag_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk   (CLK),
        .rst_n (Reset),
        .push  (do_push),
        .pop   (do_pop),
        .swap  (do_swap),
        .din   (Flagout),
        .top   (top),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_flag_ctx.sv
// Bench for flag_ctx: directed scenarios plus randomized traffic against a
// queue-based reference model of the flag register and save stack.
module tb_flag_ctx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             Reset;
    logic [WIDTH-1:0] Flagin, mask;
    logic             wrflag, push, pop, clr_err;
    logic [1:0]       mode;
    logic [WIDTH-1:0] Flagout;
    logic [DW-1:0]    depth;
    logic             full, empty, ovf_err, unf_err;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [WIDTH-1:0] m_fo;
    logic [WIDTH-1:0] m_stk[$];
    logic             m_ovf, m_unf;

    flag_ctx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .Flagin(Flagin), .wrflag(wrflag), .mode(mode),
        .mask(mask), .push(push), .pop(pop), .clr_err(clr_err), .Flagout(Flagout),
        .depth(depth), .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH-1:0] apply_mode(input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] fin, input logic [WIDTH-1:0] msk, input logic [1:0] md);
        logic [WIDTH-1:0] m;
        m = fin & msk;
        case (md)
            2'd0:    return (cur & ~msk) | m;
            2'd1:    return cur | m;
            2'd2:    return cur & ~m;
            default: return cur ^ m;
        endcase
    endfunction

    // Advance the model by one edge using the currently driven inputs.
    function automatic void model_edge();
        logic [WIDTH-1:0] pre;
        logic os, us;
        if (!Reset) begin
            m_fo = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        pre = m_fo; os = 1'b0; us = 1'b0;
        if (push && pop && m_stk.size() > 0) begin
            m_fo = m_stk[m_stk.size()-1];
            m_stk[m_stk.size()-1] = pre;
        end else if (pop && !push && m_stk.size() > 0) begin
            m_fo = m_stk.pop_back();
        end else begin
            if (pop) us = 1'b1;
            if (push) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(pre);
                else os = 1'b1;
            end
            if (wrflag) m_fo = apply_mode(pre, Flagin, mask, mode);
        end
        m_ovf = os | (m_ovf & ~clr_err);
        m_unf = us | (m_unf & ~clr_err);
    endfunction

    task automatic drive(input logic rst, input logic wr, input logic [1:0] md,
        input logic [WIDTH-1:0] fin, input logic [WIDTH-1:0] msk,
        input logic ps, input logic pp, input logic clr);
        Reset = rst; wrflag = wr; mode = md; Flagin = fin; mask = msk;
        push = ps; pop = pp; clr_err = clr;
        @(posedge CLK);
        model_edge();
        #1;
        wrflag = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; Reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        total++;
        if ({Flagout, depth, empty, full, ovf_err, unf_err} !== {8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset: Flagout=%h depth=%0d empty=%b ovf=%b unf=%b, want 00/0/1/0/0",
                     Flagout, depth, empty, ovf_err, unf_err);
            bad++;
        end
    endtask

    task automatic test_modes();
        logic [WIDTH-1:0] exp_v[4] = '{8'h3F, 8'h3A, 8'hFA, 8'hF0};
        logic [1:0]       md_v[4]  = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [WIDTH-1:0] fin_v[4] = '{8'hF0, 8'hFF, 8'hFF, 8'h00};
        logic [WIDTH-1:0] msk_v[4] = '{8'h30, 8'h05, 8'hC0, 8'h0F};
        drive(1'b1, 1'b1, 2'd0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
        total++;
        if (Flagout !== 8'h0F) begin
            $display("FAIL mode_load_init: got %h want 0F", Flagout); bad++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, md_v[i], fin_v[i], msk_v[i], 1'b0, 1'b0, 1'b0);
            total++;
            if (Flagout !== exp_v[i]) begin
                $display("FAIL mode_%0d: got %h want %h", md_v[i], Flagout, exp_v[i]); bad++;
            end
        end
        // wrflag low must hold
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        total++;
        if (Flagout !== 8'hF0) begin
            $display("FAIL hold: got %h want F0", Flagout); bad++;
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 1'b1, 2'd0, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'd0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
        total++;
        if ({Flagout, depth} !== {8'h00, 3'd1}) begin
            $display("FAIL push_save: Flagout=%h depth=%0d want 00/1", Flagout, depth); bad++;
        end
        drive(1'b1, 1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        total++;
        if ({Flagout, depth, empty} !== {8'hA5, 3'd0, 1'b1}) begin
            $display("FAIL pop_restore: Flagout=%h depth=%0d want A5/0", Flagout, depth); bad++;
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] v[6] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'd0, v[0], 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++)
            drive(1'b1, 1'b1, 2'd0, v[i], 8'hFF, 1'b1, 1'b0, 1'b0);
        total++;
        if ({depth, full, ovf_err, Flagout} !== {3'd4, 1'b1, 1'b1, v[5]}) begin
            $display("FAIL overflow: depth=%0d full=%b ovf=%b Flagout=%h want 4/1/1/%h",
                     depth, full, ovf_err, Flagout, v[5]); bad++;
        end
        for (int i = 3; i >= 0; i--) begin
            drive(1'b1, 1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
            total++;
            if ({Flagout, depth} !== {v[i], DW'(i)}) begin
                $display("FAIL lifo_pop_%0d: Flagout=%h depth=%0d want %h/%0d", i, Flagout, depth, v[i], i);
                bad++;
            end
        end
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        total++;
        if ({unf_err, Flagout, depth} !== {1'b1, v[0], 3'd0}) begin
            $display("FAIL underflow: unf=%b Flagout=%h depth=%0d want 1/%h/0", unf_err, Flagout, depth, v[0]);
            bad++;
        end
    endtask

    task automatic test_swap();
        // errors are still set from the overflow/underflow scenario
        drive(1'b1, 1'b1, 2'd0, 8'h22, 8'hFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'd0, 8'h11, 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'd0, 8'hEE, 8'hFF, 1'b1, 1'b1, 1'b0);
        total++;
        if ({Flagout, depth} !== {8'h22, 3'd1}) begin
            $display("FAIL swap: Flagout=%h depth=%0d want 22/1", Flagout, depth); bad++;
        end
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        total++;
        if ({ovf_err, unf_err} !== 2'b00) begin
            $display("FAIL clr_err: ovf=%b unf=%b want 0/0", ovf_err, unf_err); bad++;
        end
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        total++;
        if ({Flagout, depth} !== {8'h11, 3'd0}) begin
            $display("FAIL swap_top: Flagout=%h depth=%0d want 11/0", Flagout, depth); bad++;
        end
        // set and clear on the same edge: set wins
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        total++;
        if (unf_err !== 1'b1) begin
            $display("FAIL err_set_wins: unf=%b want 1", unf_err); bad++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 2'd0, 8'h77, 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2'd0, 8'h99, 8'hFF, 1'b1, 1'b0, 1'b0);
        total++;
        if ({depth, Flagout, unf_err} !== {3'd0, 8'h00, 1'b0}) begin
            $display("FAIL reset_mid: depth=%0d Flagout=%h unf=%b want 0/00/0", depth, Flagout, unf_err); bad++;
        end
        // first operation right after reset is honoured
        drive(1'b1, 1'b1, 2'd1, 8'h3C, 8'hFF, 1'b1, 1'b0, 1'b0);
        total++;
        if ({depth, Flagout} !== {3'd1, 8'h3C}) begin
            $display("FAIL after_reset: depth=%0d Flagout=%h want 1/3C", depth, Flagout); bad++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 39) != 0), 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
            total++;
            if ({Flagout, depth, full, empty, ovf_err, unf_err} !==
                {m_fo, DW'(m_stk.size()), m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_unf}) begin
                $display("FAIL random_%0d: Flagout=%h depth=%0d ovf=%b unf=%b want %h/%0d/%b/%b",
                         n, Flagout, depth, ovf_err, unf_err, m_fo, m_stk.size(), m_ovf, m_unf);
                bad++;
            end
        end
    endtask

    initial begin
        Reset = 1'b0; wrflag = 1'b0; mode = 2'd0; Flagin = '0; mask = '0;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        m_fo = '0; m_ovf = 1'b0; m_unf = 1'b0;
        test_reset();
        test_modes();
        test_push_pop();
        test_overflow();
        test_swap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_ctx.md
FLAG_CTX -- requirements
Module: flag_ctx

Interface
REQ-001 Parameter WIDTH, default 8: flag word width in bits (1..32).
REQ-002 Parameter DEPTH, default 4: context-save stack entries (1..16).
REQ-003 CLK  in  1  the only clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
REQ-005 Flagin  in  WIDTH  new flag operand.
REQ-006 wrflag  in  1  flag update enable.
REQ-007 mode  in  2  update mode: 00 LOAD, 01 SET, 10 CLEAR, 11 TOGGLE.
REQ-008 mask  in  WIDTH  per-bit write enable; 1 = bit affected.
REQ-009 push  in  1  save current flag word to stack (interrupt entry).
REQ-010 pop  in  1  restore flag word from stack (interrupt return).
REQ-011 clr_err  in  1  clears sticky error bits.
REQ-012 Flagout  out  WIDTH  registered flag word.
REQ-013 depth  out  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
REQ-014 full  out  1  depth == DEPTH; empty  out  1  depth == 0 (combinational from depth).
REQ-015 ovf_err  out  1  sticky push-when-full; unf_err  out  1  sticky pop-when-empty.

Function
REQ-016 Effective operand m = Flagin & mask; update latency is one CLK edge; Flagout is registered.
REQ-017 With wrflag=1: LOAD -> (Flagout & ~mask) | m; SET -> Flagout | m; CLEAR -> Flagout & ~m; TOGGLE -> Flagout ^ m.
REQ-018 With wrflag=0 and no accepted pop, Flagout holds.
REQ-019 Accepted push (push=1, pop=0, not full): stack[depth] <= pre-edge Flagout; depth+1; the wrflag update still applies to Flagout in the same cycle.
REQ-020 Accepted pop (pop=1, push=0, not empty): Flagout <= stack[depth-1]; depth-1; wrflag ignored that cycle (pop has priority).
REQ-021 push=1 and pop=1, not empty: swap -- Flagout <= top entry, top entry <= pre-edge Flagout, depth unchanged, wrflag ignored.
REQ-022 push=1 and pop=1, empty: pop part rejected (unf_err set), push accepted as in REQ-019.
REQ-023 push when full (pop=0): push discarded, stack and depth unchanged, ovf_err <= 1, wrflag update still applies.
REQ-024 pop when empty (push=0): no restore, depth stays 0, unf_err <= 1, wrflag update applies.
REQ-025 Error bits are sticky until clr_err=1; setting event and clr_err on the same edge -> bit ends set (set wins).
REQ-026 Stack is LIFO; entries beyond depth are don't-care and never observable on Flagout.
REQ-027 Arithmetic on depth never wraps: saturates at 0 and DEPTH per REQ-023/024.

Reset
REQ-028 Reset=0 at a CLK edge: Flagout <= 0, depth <= 0, ovf_err <= 0, unf_err <= 0; all other inputs ignored that edge.
REQ-029 Reset mid-operation (push/pop asserted) discards that operation; stack contents need not be cleared.
REQ-030 First operation after Reset returns high is honoured on that same edge's successor with no extra idle cycle.

Structure
REQ-031 Shared package flag_pkg holds the mode enum (FLAG_LOAD, FLAG_SET, FLAG_CLEAR, FLAG_TOGGLE) and default WIDTH/DEPTH constants.
REQ-032 One sub-module flag_lifo (parametrised WIDTH/DEPTH storage, pointer, full/empty); update logic and error bits stay in flag_ctx.
REQ-033 No latches, no asynchronous reset paths, single clock domain.

Verification
REQ-034 Reset=0 one edge with Flagin=FF, wrflag=1 -> Flagout=00, depth=0, empty=1, errs=0.
REQ-035 Flagout=0F; SET Flagin=F0 mask=30 -> 3F; CLEAR Flagin=FF mask=05 -> 3A; TOGGLE Flagin=FF mask=C0 -> FA; LOAD Flagin=00 mask=0F -> F0.
REQ-036 Flagout=A5; push with wrflag LOAD Flagin=00 mask=FF -> Flagout=00, depth=1; pop with wrflag=1 -> Flagout=A5, depth=0.
REQ-037 DEPTH=4: five pushes -> depth=4, full=1, ovf_err=1 after fifth; four pops return values in reverse order; fifth pop -> unf_err=1, Flagout unchanged.
REQ-038 Flagout=11, stack top=22, push&pop same edge -> Flagout=22, top=11, depth unchanged; clr_err=1 -> both errs 0.
REQ-039 Push asserted on the edge Reset=0 -> depth=0 afterwards, stack not advanced.
